// File: rtl/ddr_data_demux_2_out.sv
// rtl/ddr_data_demux_2_out.sv - one-to-two stream splitter with per-channel show-ahead FIFOs
// Optional macro DDR_DEMUX_CNT_EN adds 16-bit per-channel pop counters xfer_cnt0/xfer_cnt1.
module ddr_data_demux_2_out #(
    parameter int DW      = 323,
    parameter int SEL_BIT = 322,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout0,
    output logic          valid0,
    input  logic          ready0,
    output logic [DW-1:0] dout1,
    output logic          valid1,
    input  logic          ready1,
    output logic          busy
`ifdef DDR_DEMUX_CNT_EN
    ,
    output logic [15:0]   xfer_cnt0,
    output logic [15:0]   xfer_cnt1
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [PW-1:0] wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
    logic [CW-1:0] cnt0, cnt1;
    logic          sel;
    logic          full0, full1;
    logic          push0, push1, pop0, pop1;

    assign sel   = din[SEL_BIT];
    assign full0 = (cnt0 == CNT_FULL);
    assign full1 = (cnt1 == CNT_FULL);

    // Readiness follows only the addressed channel; a same-cycle pop does not free space early.
    assign din_ready = sel ? ~full1 : ~full0;
    assign push0     = din_valid & din_ready & ~sel;
    assign push1     = din_valid & din_ready & sel;

    assign valid0 = (cnt0 != '0);
    assign valid1 = (cnt1 != '0);
    assign pop0   = valid0 & ready0;
    assign pop1   = valid1 & ready1;
    assign busy   = valid0 | valid1;

    assign dout0 = valid0 ? mem0[rd_ptr0] : '0;
    assign dout1 = valid1 ? mem1[rd_ptr1] : '0;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem0[wr_ptr0] <= din;
        end
        if (push1) begin
            mem1[wr_ptr1] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr0 <= '0;
            rd_ptr0 <= '0;
            cnt0    <= '0;
        end else begin
            if (push0) begin
                wr_ptr0 <= wr_ptr0 + PTR_ONE;
            end
            if (pop0) begin
                rd_ptr0 <= rd_ptr0 + PTR_ONE;
            end
            case ({push0, pop0})
                2'b10:   cnt0 <= cnt0 + CNT_ONE;
                2'b01:   cnt0 <= cnt0 - CNT_ONE;
                default: cnt0 <= cnt0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr1 <= '0;
            rd_ptr1 <= '0;
            cnt1    <= '0;
        end else begin
            if (push1) begin
                wr_ptr1 <= wr_ptr1 + PTR_ONE;
            end
            if (pop1) begin
                rd_ptr1 <= rd_ptr1 + PTR_ONE;
            end
            case ({push1, pop1})
                2'b10:   cnt1 <= cnt1 + CNT_ONE;
                2'b01:   cnt1 <= cnt1 - CNT_ONE;
                default: cnt1 <= cnt1;
            endcase
        end
    end

`ifdef DDR_DEMUX_CNT_EN
    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt0 <= '0;
            xfer_cnt1 <= '0;
        end else begin
            if (pop0) begin
                xfer_cnt0 <= xfer_cnt0 + 16'd1;
            end
            if (pop1) begin
                xfer_cnt1 <= xfer_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_data_demux_2_out.sv
// tb/tb_ddr_data_demux_2_out.sv - queue-model bench for ddr_data_demux_2_out
// Define DDR_DEMUX_CNT_EN to also exercise the pop counters.
module tb_ddr_data_demux_2_out;

    localparam int DW      = 323;
    localparam int SEL_BIT = 322;
    localparam int DEPTH   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout0, dout1;
    logic          valid0, valid1;
    logic          ready0, ready1;
    logic          busy;
`ifdef DDR_DEMUX_CNT_EN
    logic [15:0]   xfer_cnt0, xfer_cnt1;
`endif

    ddr_data_demux_2_out #(.DW(DW), .SEL_BIT(SEL_BIT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout0     (dout0),
        .valid0    (valid0),
        .ready0    (ready0),
        .dout1     (dout1),
        .valid1    (valid1),
        .ready1    (ready1),
        .busy      (busy)
`ifdef DDR_DEMUX_CNT_EN
        ,
        .xfer_cnt0 (xfer_cnt0),
        .xfer_cnt1 (xfer_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two plain queues plus pop tallies.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int unsigned   pops0 = 0;
    int unsigned   pops1 = 0;

    function automatic bit model_ready(input logic [DW-1:0] w);
        return w[SEL_BIT] ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            pops0 = 0;
            pops1 = 0;
        end else begin
            bit acc;
            acc = din_valid && model_ready(din);
            if (ready0 && q0.size() > 0) begin
                void'(q0.pop_front());
                pops0++;
            end
            if (ready1 && q1.size() > 0) begin
                void'(q1.pop_front());
                pops1++;
            end
            if (acc) begin
                if (din[SEL_BIT]) q1.push_back(din);
                else              q0.push_back(din);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("valid0", DW'(valid0), DW'(q0.size() != 0));
            check("valid1", DW'(valid1), DW'(q1.size() != 0));
            check("dout0", dout0, (q0.size() != 0) ? q0[0] : '0);
            check("dout1", dout1, (q1.size() != 0) ? q1[0] : '0);
            check("busy", DW'(busy), DW'((q0.size() + q1.size()) != 0));
            check("din_ready", DW'(din_ready), DW'(model_ready(din)));
`ifdef DDR_DEMUX_CNT_EN
            check("xfer_cnt0", DW'(xfer_cnt0), DW'(pops0 & 32'hFFFF));
            check("xfer_cnt1", DW'(xfer_cnt1), DW'(pops1 & 32'hFFFF));
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word(input bit s);
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
        w[SEL_BIT] = s;
        return w;
    endfunction

    logic [DW-1:0] w5, w6, wx;
    bit            pend;

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
        tick; tick;
        check("rst_valid0", DW'(valid0), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_dout0", dout0, '0);
        rst = 1'b0;
        tick;

        // routing and one-cycle latency
        w5 = DW'(5);
        w6 = DW'(6); w6[SEL_BIT] = 1'b1;
        din = w5; din_valid = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        tick;
        din = w6;
        check("route_dout0", dout0, w5);
        check("route_valid0", DW'(valid0), DW'(1));
        check("route_valid1_idle", DW'(valid1), '0);
        tick;
        din_valid = 1'b0;
        check("route_dout1", dout1, w6);
        check("route_valid0_done", DW'(valid0), '0);
        tick;
        check("route_busy_idle", DW'(busy), '0);

        // full stall on channel 0 does not block channel 1
        ready0 = 1'b0; ready1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            din = rand_word(1'b0); din_valid = 1'b1;
            tick;
        end
        din = rand_word(1'b0);
        #1;
        check("full_stall_ready", DW'(din_ready), '0);
        wx = rand_word(1'b1);
        din = wx;
        #1;
        check("other_chan_ready", DW'(din_ready), DW'(1));
        tick;
        din_valid = 1'b0;
        check("isolated_dout1", dout1, wx);
        check("full_valid0", DW'(valid0), DW'(1));

        // drain: four pops empty channel 0, busy drops after the last
        ready0 = 1'b1; ready1 = 1'b1;
        tick; tick; tick;
        check("drain_busy_3", DW'(busy), DW'(1));
        tick;
        check("drain_busy_4", DW'(busy), '0);

        // simultaneous push/pop across pointer wrap
        ready1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din = rand_word(1'b1); din_valid = 1'b1;
            tick;
        end
        ready1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = rand_word(1'b1);
            tick;
            check("stream_valid1", DW'(valid1), DW'(1));
        end
        din_valid = 1'b0;
        tick; tick; tick;

        // asynchronous reset with channel 0 holding two words
        ready0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din = rand_word(1'b0); din_valid = 1'b1;
            tick;
        end
        din_valid = 1'b0;
        check("prerst_valid0", DW'(valid0), DW'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_valid0", DW'(valid0), '0);
        check("arst_valid1", DW'(valid1), '0);
        check("arst_busy", DW'(busy), '0);
        check("arst_dout0", dout0, '0);
        check("arst_dout1", dout1, '0);
        tick;
        rst = 1'b0;
        #1;
        check("postrst_ready", DW'(din_ready), DW'(1));

        // randomized traffic; a stalled word is held stable
        pend = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!pend) begin
                din       = rand_word(1'($urandom_range(0, 1)));
                din_valid = ($urandom_range(0, 3) != 0);
            end
            ready0 = ($urandom_range(0, 2) != 0);
            ready1 = ($urandom_range(0, 3) == 0);
            pend = din_valid && !model_ready(din);
            tick;
        end
        din_valid = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) tick;
        check("final_busy", DW'(busy), '0);

`ifdef DDR_DEMUX_CNT_EN
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ready0 = 1'b1; ready1 = 1'b0;
        din = rand_word(1'b0); din_valid = 1'b1;
        for (int i = 0; i < 70000 && pops0 < 32'h10002; i++) tick;
        din_valid = 1'b0;
        check("cnt_pops_reached", DW'(pops0), DW'(32'h10002));
        tick;
        check("xfer_cnt0_wrap", DW'(xfer_cnt0), DW'(16'h0002) + DW'(pops0 - 32'h10002));
        check("xfer_cnt1_still", DW'(xfer_cnt1), '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
